// File: rtl/sr_sched_pkg.sv
// Shared definitions for the SR command scheduler.
//   ST_*   : FSM state encodings (IDLE -> DRIVE -> CHECK -> IDLE)
//   OP_*   : command opcode carried on req_op (1 = set, 0 = reset)
//   state_e: typed FSM state built on the ST_* encodings
package sr_sched_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DRIVE = 2'd1;
  localparam logic [1:0] ST_CHECK = 2'd2;

  localparam logic OP_SET = 1'b1;
  localparam logic OP_RST = 1'b0;

  typedef enum logic [1:0] {
    StIdle  = ST_IDLE,
    StDrive = ST_DRIVE,
    StCheck = ST_CHECK
  } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
// Ports:
//   req     in  N     request vector
//   ptr     in  PTRW  highest-priority requester; the search moves upward from here with wrap
//   win     out N     one-hot winner (all zero when req is zero)
//   win_idx out PTRW  binary index of the winner (zero when req is zero)
module rr_arbiter #(
  parameter int unsigned N    = 4,
  parameter int unsigned PTRW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]    req,
  input  logic [PTRW-1:0] ptr,
  output logic [N-1:0]    win,
  output logic [PTRW-1:0] win_idx
);

  int unsigned pos;
  logic        found;

  always_comb begin
    win     = '0;
    win_idx = '0;
    found   = 1'b0;
    pos     = 0;
    for (int unsigned i = 0; i < N; i++) begin
      pos = 32'(ptr) + i;
      if (pos >= N) begin
        pos = pos - N;
      end
      if (!found && req[pos]) begin
        found    = 1'b1;
        win[pos] = 1'b1;
        win_idx  = PTRW'(pos);
      end
    end
  end

endmodule

// File: rtl/sr_flipflop.sv
// One SR flip-flop of the flag bank. Set wins if both are ever high together, which the
// scheduler never does. No reset: the bank keeps its contents across scheduler resets.
// Ports:
//   clk in  clock, rising edge
//   s   in  set
//   r   in  reset
//   q   out stored value
module sr_flipflop (
  input  logic clk,
  input  logic s,
  input  logic r,
  output logic q
);

  always_ff @(posedge clk) begin
    if (s) begin
      q <= 1'b1;
    end else if (r) begin
      q <= 1'b0;
    end
  end

endmodule

// File: rtl/sr_cmd_scheduler.sv
// Shares one bank of NFLAG SR flip-flops among NREQ requesters. A round-robin winner's
// set/reset command is driven on exactly one s_out/r_out line for one cycle, the bank output
// is verified, and a one-hot gnt pulse completes the command. All outputs are registered or
// decoded from registers only.
// Ports:
//   clk, rst       clock and synchronous active-high reset
//   req/req_op     per-requester request and opcode (1 = set, 0 = reset)
//   req_idx        per-requester target bit, requester k at [k*IDXW +: IDXW]
//   gnt            one-hot completion pulse (CHECK cycle)
//   s_out/r_out    set/reset lines to the bank
//   q_in           bank outputs
//   err            1-cycle pulse after CHECK on verify mismatch or out-of-range index
//   busy           high whenever a command is in flight
module sr_cmd_scheduler
  import sr_sched_pkg::*;
#(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned NFLAG = 8,
  parameter int unsigned IDXW  = $clog2(NFLAG)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ-1:0]      req_op,
  input  logic [NREQ*IDXW-1:0] req_idx,
  output logic [NREQ-1:0]      gnt,
  output logic [NFLAG-1:0]     s_out,
  output logic [NFLAG-1:0]     r_out,
  input  logic [NFLAG-1:0]     q_in,
  output logic                 err,
  output logic                 busy
);

  localparam int unsigned PTRW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_e              state_q, state_d;
  logic [PTRW-1:0]     ptr_q, ptr_d;
  logic [PTRW-1:0]     win_q, win_d;
  logic                op_q, op_d;
  logic [IDXW-1:0]     idx_q, idx_d;
  logic [NFLAG-1:0]    s_q, s_d;
  logic [NFLAG-1:0]    r_q, r_d;
  logic                err_q, err_d;

  logic [NREQ-1:0]     arb_win;
  logic [PTRW-1:0]     arb_idx;
  logic                sel_op;
  logic [IDXW-1:0]     sel_idx;
  logic [NFLAG-1:0]    drive_vec;
  logic                q_sel;
  logic                q_hit;

  rr_arbiter #(
    .N    (NREQ),
    .PTRW (PTRW)
  ) u_arb (
    .req     (req),
    .ptr     (ptr_q),
    .win     (arb_win),
    .win_idx (arb_idx)
  );

  // Command fields of the current arbitration winner.
  always_comb begin
    sel_op  = 1'b0;
    sel_idx = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (arb_win[k]) begin
        sel_op  = req_op[k];
        sel_idx = req_idx[k*IDXW +: IDXW];
      end
    end
  end

  // One-hot line decode; an index beyond the bank decodes to no line at all.
  always_comb begin
    drive_vec = '0;
    for (int unsigned f = 0; f < NFLAG; f++) begin
      if (32'(sel_idx) == f) begin
        drive_vec[f] = 1'b1;
      end
    end
  end

  // Bank bit addressed by the latched command; q_hit low means out of range.
  always_comb begin
    q_sel = 1'b0;
    q_hit = 1'b0;
    for (int unsigned f = 0; f < NFLAG; f++) begin
      if (32'(idx_q) == f) begin
        q_sel = q_in[f];
        q_hit = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    op_d    = op_q;
    idx_d   = idx_q;
    s_d     = '0;
    r_d     = '0;
    err_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (|req) begin
          state_d = StDrive;
          win_d   = arb_idx;
          op_d    = sel_op;
          idx_d   = sel_idx;
          if (sel_op == OP_SET) begin
            s_d = drive_vec;
          end else if (sel_op == OP_RST) begin
            r_d = drive_vec;
          end
        end
      end
      StDrive: begin
        state_d = StCheck;
      end
      StCheck: begin
        state_d = StIdle;
        err_d   = !q_hit || (q_sel != op_q);
        ptr_d   = (32'(win_q) == NREQ - 1) ? '0 : win_q + 1'b1;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      win_q   <= '0;
      op_q    <= 1'b0;
      idx_q   <= '0;
      s_q     <= '0;
      r_q     <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      op_q    <= op_d;
      idx_q   <= idx_d;
      s_q     <= s_d;
      r_q     <= r_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    gnt = '0;
    if (state_q == StCheck) begin
      for (int unsigned k = 0; k < NREQ; k++) begin
        if (32'(win_q) == k) begin
          gnt[k] = 1'b1;
        end
      end
    end
  end

  assign s_out = s_q;
  assign r_out = r_q;
  assign err   = err_q;
  assign busy  = (state_q != StIdle);

endmodule
